exu2lsu: RTL and testbench

//   Pipeline register between EXU and LSU. Carries the EXU result and the memory-control bundle

---
 rtl/exu2lsu_pkg.sv | 60 ++++++
 rtl/exu2lsu.sv | 113 +++++++++++
 tb/tb_exu2lsu.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/exu2lsu_pkg.sv
// exu2lsu_pkg: shared widths, reset constants and payload bundle for the EXU->LSU stage register.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif
`ifndef REG_WR_SRC_X
`define REG_WR_SRC_X {`ARGS_WIDTH{1'b0}}
`endif
`ifndef RAM_BYT_X
`define RAM_BYT_X {`ARGS_WIDTH{1'b0}}
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 32'h8000_0000
`endif
`ifndef DATA_ZERO
`define DATA_ZERO {`DATA_WIDTH{1'b0}}
`endif
`ifndef GPRS_ZERO
`define GPRS_ZERO {`GPRS_WIDTH{1'b0}}
`endif

package exu2lsu_pkg;
    localparam int E2L_ADDR_W = `ADDR_WIDTH;
    localparam int E2L_DATA_W = `DATA_WIDTH;
    localparam int E2L_ARGS_W = `ARGS_WIDTH;
    localparam int E2L_GPRS_W = `GPRS_WIDTH;
    localparam logic [E2L_ADDR_W-1:0] E2L_ADDR_INIT = `ADDR_INIT;

    typedef struct packed {
        logic                  reg_wr_en;
        logic [E2L_ARGS_W-1:0] reg_wr_src;
        logic                  ram_wr_en;
        logic [E2L_ARGS_W-1:0] ram_byt;
        logic [E2L_ADDR_W-1:0] pc;
        logic [E2L_DATA_W-1:0] alu_res;
        logic [E2L_DATA_W-1:0] rs2_data;
        logic [E2L_GPRS_W-1:0] gpr_wr_id;
    } e2l_pld_t;

    function automatic e2l_pld_t e2l_pld_rst();
        e2l_pld_t p;
        p.reg_wr_en  = 1'b0;
        p.reg_wr_src = `REG_WR_SRC_X;
        p.ram_wr_en  = 1'b0;
        p.ram_byt    = `RAM_BYT_X;
        p.pc         = `ADDR_INIT;
        p.alu_res    = `DATA_ZERO;
        p.rs2_data   = `DATA_ZERO;
        p.gpr_wr_id  = `GPRS_ZERO;
        return p;
    endfunction
endpackage

// File: rtl/exu2lsu.sv
// exu2lsu: EXU->LSU pipeline register with valid/ready handshake and sync flush.
// E2L_SKID_EN selects a 2-entry skid buffer with registered ready; otherwise a single register.
module exu2lsu
    import exu2lsu_pkg::*;
#(
    parameter int ADDR_W = `ADDR_WIDTH,
    parameter int DATA_W = `DATA_WIDTH,
    parameter int ARGS_W = `ARGS_WIDTH,
    parameter int GPRS_W = `GPRS_WIDTH
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst_n,
    input  logic              i_exu_valid,
    output logic              o_e2l_ready,
    input  logic              i_lsu_ready,
    output logic              o_e2l_valid,
    input  logic              i_e2l_flush,
    input  logic              i_exu_ctr_reg_wr_en,
    input  logic [ARGS_W-1:0] i_exu_ctr_reg_wr_src,
    input  logic              i_exu_ctr_ram_wr_en,
    input  logic [ARGS_W-1:0] i_exu_ctr_ram_byt,
    input  logic [ADDR_W-1:0] i_exu_pc,
    input  logic [DATA_W-1:0] i_exu_alu_res,
    input  logic [DATA_W-1:0] i_exu_gpr_rs2_data,
    input  logic [GPRS_W-1:0] i_exu_gpr_wr_id,
    output logic              o_e2l_ctr_reg_wr_en,
    output logic [ARGS_W-1:0] o_e2l_ctr_reg_wr_src,
    output logic              o_e2l_ctr_ram_wr_en,
    output logic [ARGS_W-1:0] o_e2l_ctr_ram_byt,
    output logic [ADDR_W-1:0] o_e2l_pc,
    output logic [DATA_W-1:0] o_e2l_alu_res,
    output logic [DATA_W-1:0] o_e2l_gpr_rs2_data,
    output logic [GPRS_W-1:0] o_e2l_gpr_wr_id
);
    e2l_pld_t in_pld, m_pld;
    logic     m_vld, accept, fire;

    assign in_pld = '{
        reg_wr_en:  i_exu_ctr_reg_wr_en,
        reg_wr_src: i_exu_ctr_reg_wr_src,
        ram_wr_en:  i_exu_ctr_ram_wr_en,
        ram_byt:    i_exu_ctr_ram_byt,
        pc:         i_exu_pc,
        alu_res:    i_exu_alu_res,
        rs2_data:   i_exu_gpr_rs2_data,
        gpr_wr_id:  i_exu_gpr_wr_id
    };
    assign accept = i_exu_valid & o_e2l_ready;
    assign fire   = m_vld & i_lsu_ready;

`ifdef E2L_SKID_EN
    e2l_pld_t s_pld;
    logic     s_vld;

    // Ready depends only on the skid register, breaking the path from i_lsu_ready.
    assign o_e2l_ready = !s_vld;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
            m_pld <= e2l_pld_rst();
            s_pld <= e2l_pld_rst();
        end else if (i_e2l_flush) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (!m_vld) begin
            if (accept) begin
                m_pld <= in_pld;
                m_vld <= 1'b1;
            end
        end else if (fire) begin
            if (s_vld) begin
                m_pld <= s_pld;
                s_vld <= 1'b0;
            end else if (accept) begin
                m_pld <= in_pld;
            end else begin
                m_vld <= 1'b0;
            end
        end else if (accept) begin
            s_pld <= in_pld;
            s_vld <= 1'b1;
        end
    end
`else
    assign o_e2l_ready = !m_vld | i_lsu_ready;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            m_vld <= 1'b0;
            m_pld <= e2l_pld_rst();
        end else if (i_e2l_flush) begin
            m_vld <= 1'b0;
        end else if (accept) begin
            m_pld <= in_pld;
            m_vld <= 1'b1;
        end else if (fire) begin
            m_vld <= 1'b0;
        end
    end
`endif

    assign o_e2l_valid          = m_vld;
    assign o_e2l_ctr_reg_wr_en  = m_pld.reg_wr_en;
    assign o_e2l_ctr_reg_wr_src = m_pld.reg_wr_src;
    assign o_e2l_ctr_ram_wr_en  = m_pld.ram_wr_en;
    assign o_e2l_ctr_ram_byt    = m_pld.ram_byt;
    assign o_e2l_pc             = m_pld.pc;
    assign o_e2l_alu_res        = m_pld.alu_res;
    assign o_e2l_gpr_rs2_data   = m_pld.rs2_data;
    assign o_e2l_gpr_wr_id      = m_pld.gpr_wr_id;
endmodule

// File: tb/tb_exu2lsu.sv
// tb_exu2lsu: directed and scoreboard checks for the EXU->LSU stage register.
module tb_exu2lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exu_valid = 1'b0, lsu_ready = 1'b0, flush = 1'b0;
    logic        e2l_ready, e2l_valid;
    logic        reg_wr_en, ram_wr_en;
    logic [2:0]  reg_wr_src, ram_byt;
    logic [31:0] pc, alu_res, rs2_data;
    logic [4:0]  gpr_wr_id;
    logic        o_reg_wr_en, o_ram_wr_en;
    logic [2:0]  o_reg_wr_src, o_ram_byt;
    logic [31:0] o_pc, o_alu_res, o_rs2_data;
    logic [4:0]  o_gpr_wr_id;
    logic [108:0] obs;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    exu2lsu dut (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n),
        .i_exu_valid(exu_valid), .o_e2l_ready(e2l_ready),
        .i_lsu_ready(lsu_ready), .o_e2l_valid(e2l_valid), .i_e2l_flush(flush),
        .i_exu_ctr_reg_wr_en(reg_wr_en), .i_exu_ctr_reg_wr_src(reg_wr_src),
        .i_exu_ctr_ram_wr_en(ram_wr_en), .i_exu_ctr_ram_byt(ram_byt),
        .i_exu_pc(pc), .i_exu_alu_res(alu_res), .i_exu_gpr_rs2_data(rs2_data),
        .i_exu_gpr_wr_id(gpr_wr_id),
        .o_e2l_ctr_reg_wr_en(o_reg_wr_en), .o_e2l_ctr_reg_wr_src(o_reg_wr_src),
        .o_e2l_ctr_ram_wr_en(o_ram_wr_en), .o_e2l_ctr_ram_byt(o_ram_byt),
        .o_e2l_pc(o_pc), .o_e2l_alu_res(o_alu_res), .o_e2l_gpr_rs2_data(o_rs2_data),
        .o_e2l_gpr_wr_id(o_gpr_wr_id)
    );

    assign obs = {o_reg_wr_en, o_reg_wr_src, o_ram_wr_en, o_ram_byt, o_pc, o_alu_res, o_rs2_data, o_gpr_wr_id};

    // Every payload field is derived from the pc so a single number identifies a beat.
    function automatic logic [108:0] pld(input logic [31:0] p);
        return {p[2], p[4:2], p[3], p[7:5], p, p ^ 32'h5a5a_c3c3, ~p, p[8:4]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] p);
        exu_valid = v;
        {reg_wr_en, reg_wr_src, ram_wr_en, ram_byt, pc, alu_res, rs2_data, gpr_wr_id} = pld(p);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0]  q[$];
    logic [31:0]  pc_seq;
    logic [108:0] prev_obs;
    logic         prev_stall, acc, fr;

    initial begin
        drive(0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_valid", e2l_valid, 0);
        chk("rst_ready", e2l_ready, 1);
        chk("rst_pc", o_pc, exu2lsu_pkg::E2L_ADDR_INIT);
        chk("rst_ctl", {o_reg_wr_en, o_ram_wr_en, o_gpr_wr_id, o_alu_res}, 0);

        lsu_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h8000_0000 + 32'(i * 4));
            tick();
            chk("stream_v", e2l_valid, 1);
            chk("stream_pld", obs, pld(32'h8000_0000 + 32'(i * 4)));
        end
        drive(0, 32'h0);
        tick();
        chk("stream_end", e2l_valid, 0);

        lsu_ready = 1'b0;
        drive(1, 32'h100);
        #1 chk("bp_ready_a", e2l_ready, 1);
        tick();
        chk("bp_a_v", e2l_valid, 1);
        chk("bp_a_pc", o_pc, 32'h100);
        drive(1, 32'h104);
        tick();
        chk("bp_hold_a", obs, pld(32'h100));
        chk("bp_ready_b", e2l_ready, 0);
`ifdef E2L_SKID_EN
        drive(0, 32'h0);
`endif
        lsu_ready = 1'b1;
        #1 chk("bp_out_a", o_pc, 32'h100);
        tick();
        chk("bp_out_b_v", e2l_valid, 1);
        chk("bp_out_b", obs, pld(32'h104));
        drive(0, 32'h0);
        tick();
        chk("bp_drain", e2l_valid, 0);

        lsu_ready = 1'b0;
        drive(1, 32'h1f0);
        tick();
        chk("fl_a", o_pc, 32'h1f0);
        drive(1, 32'h200);
        flush = 1'b1;
        lsu_ready = 1'b1;
        tick();
        flush = 1'b0;
        drive(0, 32'h0);
        chk("fl_v0", e2l_valid, 0);
        tick();
        chk("fl_v1", e2l_valid, 0);

        lsu_ready = 1'b0;
        drive(1, 32'h300);
        tick();
        drive(1, 32'h304);
        tick();
        drive(0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", e2l_valid, 0);
        chk("ar_ready", e2l_ready, 1);
        chk("ar_pc", o_pc, exu2lsu_pkg::E2L_ADDR_INIT);
        @(negedge clk);
        rst_n = 1'b1;
        lsu_ready = 1'b1;
        drive(1, 32'h400);
        tick();
        chk("ar_first", obs, pld(32'h400));
        drive(0, 32'h0);
        tick();
        chk("ar_empty", e2l_valid, 0);

        pc_seq = 32'h1000;
        prev_stall = 1'b0;
        prev_obs = '0;
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 1)), pc_seq);
            lsu_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                chk("hold_v", e2l_valid, 1);
                chk("hold_pld", obs, prev_obs);
            end
            acc = exu_valid & e2l_ready;
            fr = e2l_valid & lsu_ready;
            if (fr) begin
                chk("sb_nonempty", q.size() != 0, 1);
                if (q.size() != 0) chk("sb_pld", obs, pld(q.pop_front()));
            end
            if (acc) begin
                q.push_back(pc_seq);
                pc_seq += 4;
            end
            prev_stall = e2l_valid & !lsu_ready;
            prev_obs = obs;
            tick();
        end
        drive(0, 32'h0);
        lsu_ready = 1'b1;
        for (int c = 0; c < 8 && q.size() != 0; c++) begin
            #1;
            if (e2l_valid) chk("drain_pld", obs, pld(q.pop_front()));
            tick();
        end
        chk("drain_q", q.size(), 0);
        chk("drain_v", e2l_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
